// File: rtl/rgb_hue_sequencer.sv
// Purpose: cycles the RGB LED through a hue wheel with glitch-free PWM
//          (red -> yellow -> green -> cyan -> blue -> magenta -> red).
// Latency: RGB_x is registered, one clock after pwm_cnt/duty_x.
//          A new duty target takes effect at the next PWM period boundary.
// Backpressure: none. `pause` freezes the hue progression while the PWM keeps running.
// Ports:
//   clk, rst (async, active-high)  system clock and reset
//   pause                          hold prescaler, ramp and phase
//   RGB_R/G/B                      active-low PWM pins (0 = LED on)
//   phase                          current hue phase 0..5
//   cycle_done                     one-clock pulse after the 5 -> 0 wrap
module rgb_hue_sequencer #(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEP_CYCLES  = 1667
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] phase,
  output logic       cycle_done
);

  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [DW-1:0] FULL     = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] LAST     = DW'(PWM_INTERVAL - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_CYCLES - 1);

  localparam logic [2:0] P0 = 3'd0;
  localparam logic [2:0] P1 = 3'd1;
  localparam logic [2:0] P2 = 3'd2;
  localparam logic [2:0] P3 = 3'd3;
  localparam logic [2:0] P4 = 3'd4;
  localparam logic [2:0] P5 = 3'd5;

  logic [PW-1:0] pre;
  logic [DW-1:0] ramp;
  logic [DW-1:0] ramp_dn;
  logic [DW-1:0] pwm_cnt;
  logic [DW-1:0] duty_r, duty_g, duty_b;
  logic [DW-1:0] tgt_r, tgt_g, tgt_b;
  logic [2:0]    phase_nxt;
  logic          tick;
  logic          ramp_wrap;
  logic          pwm_last;

  // A tick that coincides with pause is dropped, and pre holds its value.
  assign tick      = (pre == PRE_LAST) && !pause;
  assign ramp_wrap = tick && (ramp == LAST);
  assign ramp_dn   = FULL - ramp;
  assign pwm_last  = (pwm_cnt == LAST);

  // Step prescaler and ramp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      ramp <= '0;
    end else begin
      if (!pause) begin
        pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
      end
      if (tick) begin
        ramp <= (ramp == LAST) ? '0 : ramp + DW'(1);
      end
    end
  end

  // Hue FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= P0;
      cycle_done <= 1'b0;
    end else begin
      phase      <= phase_nxt;
      cycle_done <= ramp_wrap && (phase == P5);
    end
  end

  // Hue FSM: next state. Codes 6 and 7 fall back to P0.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      P0, P1, P2, P3, P4: if (ramp_wrap) phase_nxt = phase + 3'd1;
      P5:                 if (ramp_wrap) phase_nxt = P0;
      default:            phase_nxt = P0;
    endcase
  end

  // Hue FSM: per-channel duty targets. Each phase holds one channel at full
  // scale, ramps one channel and keeps the third channel off. Adjacent phases
  // therefore meet at the same value, or at values one LSB apart.
  always_comb begin
    tgt_r = FULL;
    tgt_g = '0;
    tgt_b = '0;
    case (phase)
      P0: begin tgt_r = FULL;    tgt_g = ramp;    tgt_b = '0;      end
      P1: begin tgt_r = ramp_dn; tgt_g = FULL;    tgt_b = '0;      end
      P2: begin tgt_r = '0;      tgt_g = FULL;    tgt_b = ramp;    end
      P3: begin tgt_r = '0;      tgt_g = ramp_dn; tgt_b = FULL;    end
      P4: begin tgt_r = ramp;    tgt_g = '0;      tgt_b = FULL;    end
      P5: begin tgt_r = FULL;    tgt_g = '0;      tgt_b = ramp_dn; end
      default: begin tgt_r = FULL; tgt_g = '0;    tgt_b = '0;      end
    endcase
  end

  // Shared PWM counter. Duties load only on the last count of a period, so a
  // period is never cut short or stretched mid-way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_r  <= FULL;
      duty_g  <= '0;
      duty_b  <= '0;
      RGB_R   <= 1'b1;
      RGB_G   <= 1'b1;
      RGB_B   <= 1'b1;
    end else begin
      pwm_cnt <= pwm_last ? '0 : pwm_cnt + DW'(1);
      if (pwm_last) begin
        duty_r <= tgt_r;
        duty_g <= tgt_g;
        duty_b <= tgt_b;
      end
      RGB_R <= !(pwm_cnt < duty_r);
      RGB_G <= !(pwm_cnt < duty_g);
      RGB_B <= !(pwm_cnt < duty_b);
    end
  end

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Directed bench for rgb_hue_sequencer with M = 8 and STEP_CYCLES = 4.
// Clock edges are numbered 1.. from reset release. Outputs are sampled 1 ns
// after each edge and recorded. Checks then run against hand-computed values.
module tb_rgb_hue_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pause;
  logic       RGB_R, RGB_G, RGB_B;
  logic [2:0] phase;
  logic       cycle_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Samples recorded after edge k (index k).
  int r_a  [256];
  int g_a  [256];
  int b_a  [256];
  int ph_a [256];
  int cd_a [256];
  int rmp_a[256];
  int pre_a[256];

  // RGB_R / RGB_G low-clock counts for PWM periods 4..9 (P0 end through P2 start).
  int exp_r[6] = '{8, 7, 5, 3, 1, 0};
  int exp_g[6] = '{7, 8, 8, 8, 8, 8};

  rgb_hue_sequencer #(.PWM_INTERVAL(8), .STEP_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pause      (pause),
    .RGB_R      (RGB_R),
    .RGB_G      (RGB_G),
    .RGB_B      (RGB_B),
    .phase      (phase),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Runs n clock edges and records the outputs. Pause is raised after edge
  // p_on is sampled and dropped after edge p_off is sampled (0 = unused).
  task automatic run_record(input int n, input int p_on, input int p_off);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      r_a[k]   = int'(RGB_R);
      g_a[k]   = int'(RGB_G);
      b_a[k]   = int'(RGB_B);
      ph_a[k]  = int'(phase);
      cd_a[k]  = int'(cycle_done);
      rmp_a[k] = int'(dut.ramp);
      pre_a[k] = int'(dut.pre);
      if (k == p_on)  pause = 1'b1;
      if (k == p_off) pause = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  // Low (LED on) clocks in the PWM period that covers recorded edges first..first+7.
  function automatic int lows(input int ch, input int first);
    int n = 0;
    for (int k = first; k < first + 8; k++) begin
      case (ch)
        0:       if (r_a[k] == 0) n++;
        1:       if (g_a[k] == 0) n++;
        default: if (b_a[k] == 0) n++;
      endcase
    end
    return n;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cd_cnt;
    rst   = 1'b1;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);

    // Reset asserted mid-run, between clock edges.
    #3 rst = 1'b1;
    #1;
    check("rst_async_r", int'(RGB_R), 1);
    check("rst_async_g", int'(RGB_G), 1);
    check("rst_async_b", int'(RGB_B), 1);
    check("rst_async_phase", int'(phase), 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_r", int'(RGB_R), 1);
    check("rst_hold_phase", int'(phase), 0);
    check("rst_hold_cd", int'(cycle_done), 0);
    @(negedge clk) rst = 1'b0;

    // Free run from release.
    run_record(200, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("post_rst_r%0d", k), r_a[k], 0);
      check($sformatf("post_rst_g%0d", k), g_a[k], 1);
      check($sformatf("post_rst_b%0d", k), b_a[k], 1);
    end
    check("phase_e31", ph_a[31], 0);
    check("phase_e32", ph_a[32], 1);
    check("phase_e159", ph_a[159], 4);
    check("phase_e160", ph_a[160], 5);
    check("phase_e191", ph_a[191], 5);
    check("phase_e192", ph_a[192], 0);
    check("cycle_done_e192", cd_a[192], 1);
    cd_cnt = 0;
    for (int k = 1; k <= 200; k++) if (cd_a[k] == 1) cd_cnt++;
    check("cycle_done_count", cd_cnt, 1);

    // P0, ramp 3 latched at edge 16: period covers edges 17..24.
    check("p0_ramp3_g_low", lows(1, 17), 3);
    check("p0_ramp3_r_low", lows(0, 17), 8);
    check("p0_ramp3_b_low", lows(2, 17), 0);

    // Red ramps down across P1 into P2 while green stays full.
    for (int i = 0; i < 6; i++) begin
      check($sformatf("r_dn_period%0d", i + 4), lows(0, 8 * (i + 4) + 1), exp_r[i]);
      check($sformatf("g_full_period%0d", i + 4), lows(1, 8 * (i + 4) + 1), exp_g[i]);
    end
    check("p2_b_up_period9", lows(2, 73), 1);

    // Pause across edges 11..60.
    apply_reset();
    run_record(100, 10, 60);
    check("pause_ramp_e10", rmp_a[10], 2);
    check("pause_pre_e10", pre_a[10], 2);
    check("pause_ramp_e60", rmp_a[60], 2);
    check("pause_pre_e60", pre_a[60], 2);
    check("pause_phase_e60", ph_a[60], 0);
    for (int j = 2; j <= 7; j++) begin
      check($sformatf("pause_g_period%0d", j), lows(1, 8 * j + 1), 2);
      check($sformatf("pause_r_period%0d", j), lows(0, 8 * j + 1), 8);
    end
    check("resume_g_period8", lows(1, 65), 3);
    check("resume_phase_e81", ph_a[81], 0);
    check("resume_phase_e82", ph_a[82], 1);

    // Async reset while pwm_cnt = 5.
    apply_reset();
    run_record(13, 0, 0);
    check("mid_pwm_cnt", int'(dut.pwm_cnt), 5);
    check("mid_r_before", int'(RGB_R), 0);
    #2 rst = 1'b1;
    #1;
    check("mid_async_r", int'(RGB_R), 1);
    check("mid_async_g", int'(RGB_G), 1);
    check("mid_async_b", int'(RGB_B), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    run_record(8, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("mid_post_r%0d", k), r_a[k], 0);
      check($sformatf("mid_post_g%0d", k), g_a[k], 1);
      check($sformatf("mid_post_b%0d", k), b_a[k], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
